piso_serializer4: RTL and testbench
===================================

Name: piso_serializer4

Overview:
Downstream stage of the 4-bit clearable holding register. Consumes the register's parallel word `A` through a valid/ready handshake and shifts it out one bit per clock as a framed serial stream. The stream carries a `last` marker on the final bit of each frame and supports back-to-back frames with no idle gap. Single clock domain.

Parameters:
- WIDTH, 4, parallel word width in bits (legal range 2..16).
- MSB_FIRST, 1, shift order: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clear  in  1  synchronous, active-high reset.
- din  in  WIDTH  parallel word; driven by the holding register's A output.
- din_valid  in  1  din holds a word to send.
- din_ready  out  1  block accepts din at this edge; combinational from state.
- sout  out  1  serial data bit; registered.
- sout_valid  out  1  sout carries a frame bit; registered.
- last  out  1  sout is the final bit of the frame; registered.
- busy  out  1  a frame is in progress; registered.

Behaviour:
- Reset values (clear=1 at an edge): state=IDLE, shreg=0, cnt=0, sout=0, sout_valid=0, last=0, busy=0. clear dominates every other input.
- din_ready = (state==IDLE) || (state==SHIFT && last).
- Accept occurs when din_valid && din_ready && !clear at a rising edge. On that edge:
  - din is loaded into shreg.
  - The first bit is driven on sout, with sout_valid=1 and busy=1.
  - cnt is set to FRAME_LEN-1 and state goes to SHIFT.
  - Latency: first bit is valid in the cycle immediately after the accept edge.
- FRAME_LEN = WIDTH, or WIDTH+1 with the optional feature.
- SHIFT: each edge presents the next bit and decrements cnt. `last`=1 in the cycle where the final frame bit is on sout.
- End of frame, at the edge following the last bit:
  - If an accept occurs, the new frame's first bit follows with no gap; sout_valid stays 1.
  - Otherwise state goes to IDLE with sout_valid=0, last=0, busy=0. sout holds its last value (don't-care).
- While in SHIFT with last=0, din and din_valid are ignored. A change on din never corrupts the frame in flight.
- clear mid-frame aborts the frame. Remaining bits are never emitted, and din_ready=1 in the next cycle.
- There is no downstream backpressure: the stream runs at one bit per cycle.
- cnt width is clog2(WIDTH+1). Wrap below 0 is unreachable.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined: one even-parity bit (XOR of the accepted word, captured at accept) is appended after the data bits. FRAME_LEN=WIDTH+1, and `last` marks the parity bit.
- Undefined: no parity logic is present, FRAME_LEN=WIDTH, and `last` marks the final data bit.

Decomposition:
- Package serial_pkg:
  - state typedef enum {IDLE, SHIFT}.
  - Function frame_len(width, parity) returning the frame length.
  - Constant PARITY_BITS, set to 0 or 1 under the macro.
- Sub-module piso_bit_counter (load value, decrement, terminal-count flag) is natural. The shift register and FSM stay in the top module.

Test Plan:
- Basic frame (MSB_FIRST=1): clear held 2 cycles, then din=1011 with din_valid pulsed 1 cycle.
  - sout = 1,0,1,1 on cycles t+1..t+4, with sout_valid=1 throughout.
  - last=1 only at t+4.
  - Then sout_valid=0, busy=0, din_ready=1.
- LSB-first (MSB_FIRST=0): din=1011 produces sout=1,1,0,1.
- Back-to-back: din_valid held high, din=1011 then 0110 presented in the last-bit cycle.
  - 8 contiguous bits 1,0,1,1,0,1,1,0 with sout_valid never dropping.
  - last pulses at bit 4 and bit 8.
- Mid-frame clear: assert clear after 2 bits of 1011.
  - Next cycle: sout_valid=0, last=0, busy=0, din_ready=1.
  - Bits 1,1 are never emitted. A fresh 0110 frame then sends correctly.
- Input change while busy: din switches from 1011 to 0000 during SHIFT with din_valid=1.
  - Output remains 1,0,1,1.
  - The 0000 word is accepted only in the last-bit cycle.
- PISO_PARITY_EN defined:
  - din=1011 produces sout=1,0,1,1,1, with last on the 5th bit.
  - din=0110 produces 0,1,1,0,0.

Source files
------------

// File: rtl/piso_serializer4_pkg.sv
// Shared types and frame-length helpers for the PISO serializer.
// PISO_PARITY_EN adds one even-parity bit to every frame.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

`ifdef PISO_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  function automatic int unsigned frame_len(input int unsigned width,
                                            input int unsigned parity);
    return width + parity;
  endfunction

endpackage

// File: rtl/piso_serializer4_if.sv
// Parallel-in handshake plus framed serial-out stream of the PISO serializer.
interface piso_serializer4_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             last;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, last, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, last, busy
  );
endinterface

// File: rtl/piso_serializer4_bit_counter.sv
// Down-counter of bits remaining in the current frame; o_tc flags zero.
module piso_bit_counter #(
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  output logic [CW-1:0] o_cnt,
  output logic          o_tc
);
  logic [CW-1:0] r_cnt;
  logic          w_tc;

  assign w_tc  = (r_cnt == '0);
  assign o_tc  = w_tc;
  assign o_cnt = r_cnt;

  always_ff @(posedge clk) begin
    if (clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && !w_tc) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end
endmodule

// File: rtl/piso_serializer4.sv
// Parallel-in serial-out framer: accepts a word on valid/ready, shifts it out one bit per clock.
// Define PISO_PARITY_EN to append an even-parity bit marked by last.
module piso_serializer4
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic               clk,
  input logic               clear,
  piso_serializer4_if.slave bus
);
  localparam int unsigned FRAME_LEN = frame_len(WIDTH, PARITY_BITS);
  localparam int unsigned CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(FRAME_LEN - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic             r_sout;
  logic             r_sout_valid;
  logic             r_last;
  logic             r_busy;
`ifdef PISO_PARITY_EN
  logic             r_parity;
`endif

  logic          w_ready;
  logic          w_accept;
  logic          w_dec;
  logic          w_tc;
  logic [CW-1:0] w_cnt;
  logic          w_first_bit;
  logic          w_next_bit;

  assign w_ready  = (r_state == IDLE) || ((r_state == SHIFT) && r_last);
  assign w_accept = bus.din_valid && w_ready && !clear;
  assign w_dec    = (r_state == SHIFT) && !w_tc;

  assign bus.din_ready  = w_ready;
  assign bus.sout       = r_sout;
  assign bus.sout_valid = r_sout_valid;
  assign bus.last       = r_last;
  assign bus.busy       = r_busy;

  // shreg keeps the unsent bits at the outgoing end, so the bit after sout sits one position in.
  always_comb begin
    w_first_bit = MSB_FIRST ? bus.din[WIDTH-1] : bus.din[0];
    w_next_bit  = MSB_FIRST ? r_shreg[WIDTH-2] : r_shreg[1];
`ifdef PISO_PARITY_EN
    if (w_cnt == CW'(1)) begin
      w_next_bit = r_parity;
    end
`endif
  end

  piso_bit_counter #(
    .CW (CW)
  ) u_cnt (
    .clk        (clk),
    .clear      (clear),
    .i_load     (w_accept),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_dec),
    .o_cnt      (w_cnt),
    .o_tc       (w_tc)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state      <= IDLE;
      r_shreg      <= '0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_last       <= 1'b0;
      r_busy       <= 1'b0;
`ifdef PISO_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else if (w_accept) begin
      r_state      <= SHIFT;
      r_shreg      <= bus.din;
      r_sout       <= w_first_bit;
      r_sout_valid <= 1'b1;
      r_last       <= 1'b0;
      r_busy       <= 1'b1;
`ifdef PISO_PARITY_EN
      r_parity     <= ^bus.din;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_sout_valid <= 1'b0;
          r_last       <= 1'b0;
          r_busy       <= 1'b0;
        end
        SHIFT: begin
          if (r_last) begin
            r_state      <= IDLE;
            r_sout_valid <= 1'b0;
            r_last       <= 1'b0;
            r_busy       <= 1'b0;
          end else begin
            r_sout  <= w_next_bit;
            r_shreg <= MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);
            r_last  <= (w_cnt == CW'(1));
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_piso_serializer4.sv
// Self-checking bench: MSB-first and LSB-first instances share stimulus; a cycle-exact
// scoreboard of expected stream entries is filled at drive time and drained after every edge.
module tb_piso_serializer4;
  localparam int unsigned W = 4;
`ifdef PISO_PARITY_EN
  localparam int unsigned FL = W + 1;
`else
  localparam int unsigned FL = W;
`endif

  typedef struct packed {
    logic v;
    logic b;
    logic l;
  } exp_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  exp_t qm[$];
  exp_t ql[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  piso_serializer4_if #(.WIDTH(W)) ifm ();
  piso_serializer4_if #(.WIDTH(W)) ifl ();

  piso_serializer4 #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk   (clk),
    .clear (clr),
    .bus   (ifm)
  );

  piso_serializer4 #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk   (clk),
    .clear (clr),
    .bus   (ifl)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] w);
    ifm.din_valid = v;
    ifl.din_valid = v;
    ifm.din       = w;
    ifl.din       = w;
  endtask

  // Expected serial entries for one accepted word, in both shift orders.
  task automatic push_frame(input logic [W-1:0] w);
    exp_t e;
    for (int i = 0; i < int'(FL); i++) begin
      e.v = 1'b1;
      e.l = (i == int'(FL) - 1);
      e.b = (i < int'(W)) ? w[W-1-i] : ^w;
      qm.push_back(e);
      e.b = (i < int'(W)) ? w[i] : ^w;
      ql.push_back(e);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic sv, input logic so,
                     input logic la, input logic bu, input logic rd);
    check_eq({tag, ".sout_valid"}, {31'd0, sv}, {31'd0, e.v});
    check_eq({tag, ".last"},       {31'd0, la}, {31'd0, e.l});
    check_eq({tag, ".busy"},       {31'd0, bu}, {31'd0, e.v});
    check_eq({tag, ".din_ready"},  {31'd0, rd}, {31'd0, (!e.v || e.l)});
    if (e.v) check_eq({tag, ".sout"}, {31'd0, so}, {31'd0, e.b});
  endtask

  task automatic step();
    exp_t em;
    exp_t el;
    @(posedge clk);
    #1;
    if (clr) begin
      qm.delete();
      ql.delete();
    end
    em = (qm.size() > 0) ? qm.pop_front() : '0;
    el = (ql.size() > 0) ? ql.pop_front() : '0;
    cmp("msb", em, ifm.sout_valid, ifm.sout, ifm.last, ifm.busy, ifm.din_ready);
    cmp("lsb", el, ifl.sout_valid, ifl.sout, ifl.last, ifl.busy, ifl.din_ready);
  endtask

  initial begin
    logic [W-1:0] w;
    drive(1'b0, '0);
    clr = 1'b1;
    step();
    step();
    clr = 1'b0;
    step();

    // Single frame of 1011 with a one-cycle valid pulse.
    drive(1'b1, 4'b1011);
    push_frame(4'b1011);
    step();
    drive(1'b0, 4'b1011);
    repeat (FL) step();

    // Back-to-back: valid held, second word presented in the last-bit cycle.
    drive(1'b1, 4'b1011);
    push_frame(4'b1011);
    step();
    repeat (FL - 1) step();
    drive(1'b1, 4'b0110);
    push_frame(4'b0110);
    step();
    drive(1'b0, '0);
    repeat (FL) step();

    // Clear after two bits aborts the frame; a fresh frame follows.
    drive(1'b1, 4'b1011);
    push_frame(4'b1011);
    step();
    drive(1'b0, '0);
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    drive(1'b1, 4'b0110);
    push_frame(4'b0110);
    step();
    drive(1'b0, '0);
    repeat (FL) step();

    // din changes while busy; the new word is taken only at the last bit.
    drive(1'b1, 4'b1011);
    push_frame(4'b1011);
    step();
    drive(1'b1, 4'b0000);
    push_frame(4'b0000);
    repeat (FL - 1) step();
    step();
    drive(1'b0, '0);
    repeat (FL) step();

    // Random words, back-to-back with continuous valid.
    w = W'($urandom);
    drive(1'b1, w);
    push_frame(w);
    step();
    for (int k = 0; k < 6; k++) begin
      repeat (FL - 1) step();
      w = W'($urandom);
      drive(1'b1, w);
      push_frame(w);
      step();
    end
    drive(1'b0, '0);
    repeat (FL + 1) step();

    check_eq("drain", qm.size() + ql.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
